// File: rtl/match_req_arbiter_pkg.sv
// Shared widths and payload types for the match request arbiter.
package match_req_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH      = 16;
  localparam int unsigned LAZY_MATCH_LEN  = 4;
  localparam int unsigned MATCH_LEN_WIDTH = 8;
  localparam int unsigned NUM_PE_DEF      = 4;
  localparam int unsigned PE_ID_W         = $clog2(NUM_PE_DEF);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     head_addr;
    logic [ADDR_WIDTH-1:0]     history_addr;
    logic [LAZY_MATCH_LEN-1:0] tag;
  } match_req_t;

  typedef struct packed {
    logic [MATCH_LEN_WIDTH-1:0] len;
    logic [LAZY_MATCH_LEN-1:0]  tag;
  } match_resp_t;

endpackage

// File: rtl/match_id_fifo.sv
// In-order FIFO of requester IDs; head is meaningful only when not empty.
module match_id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_id;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/match_req_arbiter.sv
// Round-robin sharing of one in-order match unit between NUM_PE job PEs.
module match_req_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PE          = NUM_PE_DEF,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PE-1:0]                pe_req_valid,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]     pe_req_head_addr,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]     pe_req_history_addr,
  input  logic [NUM_PE*LAZY_MATCH_LEN-1:0] pe_req_tag,
  output logic [NUM_PE-1:0]                pe_req_ready,
  output logic [NUM_PE-1:0]                pe_resp_valid,
  output logic [MATCH_LEN_WIDTH-1:0]       pe_resp_len,
  output logic [LAZY_MATCH_LEN-1:0]        pe_resp_tag,
  input  logic [NUM_PE-1:0]                pe_resp_ready,
  output logic                             mu_req_valid,
  output logic [ADDR_WIDTH-1:0]            mu_req_head_addr,
  output logic [ADDR_WIDTH-1:0]            mu_req_history_addr,
  output logic [LAZY_MATCH_LEN-1:0]        mu_req_tag,
  input  logic                             mu_req_ready,
  input  logic                             mu_resp_valid,
  input  logic [MATCH_LEN_WIDTH-1:0]       mu_resp_len,
  input  logic [LAZY_MATCH_LEN-1:0]        mu_resp_tag,
  output logic                             mu_resp_ready,
  output logic                             err_orphan_resp
);

  localparam int unsigned ID_W  = $clog2(NUM_PE);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_mu_valid;
  match_req_t          r_mu_req;
  logic                r_err;

  logic [2*NUM_PE-1:0] w_dbl;
  logic [NUM_PE-1:0]   w_rot;
  logic [ID_W-1:0]     w_sel;
  logic [ID_W-1:0]     w_win;
  logic                w_any;
  logic                w_can_grant;
  logic                w_grant;
  logic                w_push;
  logic                w_pop;
  match_req_t          w_win_req;
  match_resp_t         w_resp;
  logic [ID_W-1:0]     w_head;
  logic [CNT_W-1:0]    w_count;
  logic                w_empty;
  logic                w_full;

  // Credit uses start-of-cycle occupancy, so a same-cycle pop frees nothing yet.
  assign w_can_grant = !rst && (!r_mu_valid || mu_req_ready) &&
                       (w_count < CNT_W'(MAX_OUTSTANDING));

  assign w_dbl = {pe_req_valid, pe_req_valid};

  // Rotate requests by rr_ptr, pick the lowest set bit, rotate the index back.
  always_comb begin
    w_rot = NUM_PE'(w_dbl >> r_rr_ptr);
    w_any = |w_rot;
    w_sel = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (w_rot[k]) w_sel = ID_W'(k);
    end
    w_win   = w_sel + r_rr_ptr;
    w_grant = w_can_grant && w_any;
    pe_req_ready = '0;
    if (w_grant) pe_req_ready[w_win] = 1'b1;
    w_win_req.head_addr    = pe_req_head_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    w_win_req.history_addr = pe_req_history_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    w_win_req.tag          = pe_req_tag[int'(w_win)*LAZY_MATCH_LEN +: LAZY_MATCH_LEN];
  end

  assign w_push = w_grant && !w_full;

  // Output register toward the match unit, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mu_valid <= 1'b0;
      r_mu_req   <= '0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_mu_valid <= 1'b1;
      r_mu_req   <= w_win_req;
      r_rr_ptr   <= w_win + ID_W'(1);
    end else if (mu_req_ready) begin
      r_mu_valid <= 1'b0;
    end
  end

  assign mu_req_valid        = r_mu_valid;
  assign mu_req_head_addr    = r_mu_req.head_addr;
  assign mu_req_history_addr = r_mu_req.history_addr;
  assign mu_req_tag          = r_mu_req.tag;

  // Steer responses to the PE at the FIFO head; nothing routes when empty.
  always_comb begin
    pe_resp_valid = '0;
    mu_resp_ready = 1'b0;
    if (!rst && !w_empty) begin
      pe_resp_valid[w_head] = mu_resp_valid;
      mu_resp_ready         = pe_resp_ready[w_head];
    end
  end

  assign w_pop       = mu_resp_valid && mu_resp_ready;
  assign w_resp      = '{len: mu_resp_len, tag: mu_resp_tag};
  assign pe_resp_len = w_resp.len;
  assign pe_resp_tag = w_resp.tag;

  // Sticky flag for a response with no request outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_empty && mu_resp_valid) begin
      r_err <= 1'b1;
    end
  end

  assign err_orphan_resp = r_err;

  match_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .push_id (w_win),
    .pop     (w_pop),
    .head    (w_head),
    .count   (w_count),
    .empty   (w_empty),
    .full    (w_full)
  );

endmodule
